// File: rtl/addsub_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : addsub_pipe_if                                              |
// | Purpose    : Operand/result stream bundle for addsub_pipe.               |
// |              Input side: in_valid/in_ready with a, b, c_in, sub.         |
// |              Output side: out_valid/out_ready with sum, c_out, ovf, zero.|
// | Modports   : master - stream producer/consumer (drives operands and      |
// |                       out_ready, observes results)                       |
// |              slave  - the arithmetic pipeline itself                     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : addsub_pipe                                                 |
// | Purpose    : Pipelined ripple-carry adder/subtractor. The WIDTH-bit      |
// |              operation is cut into STAGES segments of SEG bits; each     |
// |              rank ripples one segment and hands its carry to the next.   |
// |              Carry, signed overflow and zero flags travel with the sum.  |
// | Ports      : clk  - rising-edge clock                                    |
// |              rst  - synchronous active-high reset                        |
// |              bus  - addsub_pipe_if.slave (operand and result streams)    |
// | Parameters : WIDTH  - operand/result width, multiple of STAGES           |
// |              STAGES - pipeline ranks, 1..WIDTH                           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus
);

  // Guarded so an illegal STAGES still reaches the elaboration error below
  // instead of dividing by zero first.
  localparam int SEG  = (STAGES >= 1 && STAGES <= WIDTH) ? WIDTH / STAGES : 1;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("addsub_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Per-rank state. r_mix holds the beat as it is being worked on: bits
  // below the rank's boundary are finished sum, bits above are still the
  // untouched A operand. r_bx holds the (possibly inverted) B operand; only
  // its unprocessed upper bits are consumed downstream.
  logic             r_v   [STAGES];
  logic             r_c   [STAGES];
  logic [WIDTH-1:0] r_mix [STAGES];
  logic [WIDTH-1:0] r_bx  [STAGES];
  logic             r_ovf;
  logic             r_zero;

  // Already-consumed B bits are dead after their rank; gathered here so the
  // intent is explicit and synthesis trims the flops.
  logic [STAGES-1:0] w_unused_bx;

  // Whole pipeline moves together; it only stops when a finished result is
  // waiting on a consumer that is not ready.
  logic en;
  assign en           = ~r_v[LAST] | bus.out_ready;
  assign bus.in_ready = en;

  assign bus.out_valid = r_v[LAST];
  assign bus.sum       = r_mix[LAST];
  assign bus.c_out     = r_c[LAST];
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

  for (genvar k = 0; k < STAGES; k++) begin : g_rank
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [WIDTH-1:0] w_mix_in;
    logic [WIDTH-1:0] w_bx_in;
    logic             w_c_in;
    logic             w_v_in;
    logic [SEG:0]     w_seg;
    logic [WIDTH-1:0] w_mix_nxt;

    if (k == 0) begin : g_first
      // Subtract is A + ~B + ~borrow: invert B and the carry-in once, here,
      // so every rank is a plain adder.
      assign w_mix_in = bus.a;
      assign w_bx_in  = bus.b ^ {WIDTH{bus.sub}};
      assign w_c_in   = bus.c_in ^ bus.sub;
      assign w_v_in   = bus.in_valid;
    end else begin : g_next
      assign w_mix_in = r_mix[k-1];
      assign w_bx_in  = r_bx[k-1];
      assign w_c_in   = r_c[k-1];
      assign w_v_in   = r_v[k-1];
    end

    // One SEG-bit ripple with its carry-out in the top bit.
    assign w_seg = {1'b0, w_mix_in[HI-1:LO]}
                 + {1'b0, w_bx_in[HI-1:LO]}
                 + {{SEG{1'b0}}, w_c_in};

    always_comb begin
      w_mix_nxt        = w_mix_in;
      w_mix_nxt[HI-1:LO] = w_seg[SEG-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[k]   <= 1'b0;
        r_c[k]   <= 1'b0;
        r_mix[k] <= '0;
        r_bx[k]  <= '0;
      end else if (en) begin
        r_v[k]   <= w_v_in;
        r_c[k]   <= w_seg[SEG];
        r_mix[k] <= w_mix_nxt;
        r_bx[k]  <= w_bx_in;
      end
    end

    assign w_unused_bx[k] = ^r_bx[k][HI-1:0];

    if (k == LAST) begin : g_flags
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
      logic w_c_msb;
      assign w_c_msb = w_mix_in[WIDTH-1] ^ w_bx_in[WIDTH-1] ^ w_seg[SEG-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (en) begin
          r_ovf  <= w_c_msb ^ w_seg[SEG];
          r_zero <= ~|w_mix_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_addsub_pipe                                              |
// | Purpose    : Self-checking bench for addsub_pipe. Three instances:       |
// |              16-bit/4 ranks (directed, random stream with stalls,        |
// |              mid-flight reset), 8-bit/1 rank and 8-bit/8 ranks (sweep of |
// |              all A values against a set of B values, add and sub, both   |
// |              carry-in values, fixed-latency check).                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_addsub_pipe;

  typedef struct {
    logic [18:0] res;   // {c_out, ovf, zero, sum[15:0]}
    int          t;     // edge index on which the beat was accepted
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_pipe_if #(.WIDTH(16)) bw ();
  addsub_pipe_if #(.WIDTH(8))  b1 ();
  addsub_pipe_if #(.WIDTH(8))  b8 ();

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut_w16 (.clk(clk), .rst(rst), .bus(bw));
  addsub_pipe #(.WIDTH(8),  .STAGES(1)) dut_s1  (.clk(clk), .rst(rst), .bus(b1));
  addsub_pipe #(.WIDTH(8),  .STAGES(8)) dut_s8  (.clk(clk), .rst(rst), .bus(b8));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers: unsigned value for carry/borrow,
  // signed value for overflow.
  function automatic logic [18:0] ref_result(input int w, input logic [15:0] a,
                                             input logic [15:0] b, input logic cin,
                                             input logic sub);
    longint md, ua, ub, sa, sb, ci, r, sr;
    logic [15:0] s;
    logic c, v, z;
    md = longint'(1) << w;
    ua = longint'({48'd0, a});
    ub = longint'({48'd0, b});
    ci = cin ? 1 : 0;
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (sub) begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      c  = (r >= 0);
    end else begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      c  = (r >= md);
    end
    s = 16'((r + md) % md);
    v = (sr < -(md / 2)) || (sr > (md / 2) - 1);
    z = (s == 16'd0);
    return {c, v, z, s};
  endfunction

  // ---------------- 16-bit monitor: scoreboard, in_ready, stall hold -------
  exp_t        q16[$];
  logic [18:0] got16, held16;
  bit          held_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      held_v = 1'b0;
    end else begin
      got16 = {bw.c_out, bw.ovf, bw.zero, bw.sum};
      check_eq("w16_in_ready", {31'd0, bw.in_ready}, {31'd0, (!bw.out_valid || bw.out_ready)});
      if (held_v)
        check_eq("w16_stall_hold", {bw.out_valid, got16}, {1'b1, held16});
      held_v = bw.out_valid && !bw.out_ready;
      held16 = got16;
      if (bw.out_valid && bw.out_ready) begin
        if (q16.size() == 0) check_eq("w16_unexpected_beat", 32'd1, 32'd0);
        else check_eq("w16_result", got16, q16.pop_front().res);
      end
      if (bw.in_valid && bw.in_ready)
        q16.push_back('{res: ref_result(16, bw.a, bw.b, bw.c_in, bw.sub), t: cyc + 1});
    end
  end

  // ---------------- 8-bit monitors: result and fixed latency ---------------
  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q8.delete();
    end else begin
      if (b1.in_valid) check_eq("s1_in_ready", {31'd0, b1.in_ready}, 32'd1);
      if (b8.in_valid) check_eq("s8_in_ready", {31'd0, b8.in_ready}, 32'd1);
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) check_eq("s1_unexpected_beat", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          check_eq("s1_result", {13'd0, b1.c_out, b1.ovf, b1.zero, 8'd0, b1.sum}, {13'd0, e1.res});
          check_eq("s1_latency", cyc - e1.t, 32'd0);
        end
      end
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) check_eq("s8_unexpected_beat", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check_eq("s8_result", {13'd0, b8.c_out, b8.ovf, b8.zero, 8'd0, b8.sum}, {13'd0, e8.res});
          check_eq("s8_latency", cyc - e8.t, 32'd7);
        end
      end
      if (b1.in_valid && b1.in_ready)
        q1.push_back('{res: ref_result(8, {8'd0, b1.a}, {8'd0, b1.b}, b1.c_in, b1.sub), t: cyc + 1});
      if (b8.in_valid && b8.in_ready)
        q8.push_back('{res: ref_result(8, {8'd0, b8.a}, {8'd0, b8.b}, b8.c_in, b8.sub), t: cyc + 1});
    end
  end

  // Random back-pressure on the 16-bit output while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bw.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // One beat into an empty, non-stalled 16-bit pipe; checks latency and the
  // hand-computed result.
  task automatic send16_directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic [18:0] exp);
    int n;
    bw.a = a; bw.b = b; bw.c_in = cin; bw.sub = sub; bw.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bw.in_valid = 1'b0;
    n = 0;
    while (!bw.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_latency"}, n, 32'd3);
    check_eq(tag, {13'd0, bw.c_out, bw.ovf, bw.zero, bw.sum}, {13'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit reached, expected test end");
    $fatal(1);
  end

  logic [7:0] b_extra [4] = '{8'h01, 8'h7F, 8'h80, 8'hFE};

  initial begin
    int   n;
    int   seen;
    bit   acc;
    logic [7:0] bv;

    rst = 1'b1;
    bw.in_valid = 1'b0; bw.a = '0; bw.b = '0; bw.c_in = 1'b0; bw.sub = 1'b0; bw.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.c_in = 1'b0; b1.sub = 1'b0; b1.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.c_in = 1'b0; b8.sub = 1'b0; b8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_eq("rst_out_valid", {31'd0, bw.out_valid}, 32'd0);
    check_eq("rst_outputs", {13'd0, bw.c_out, bw.ovf, bw.zero, bw.sum}, 32'd0);
    check_eq("rst_in_ready", {31'd0, bw.in_ready}, 32'd1);
    check_eq("rst_s8_outputs", {21'd0, b8.out_valid, b8.c_out, b8.ovf, b8.zero, b8.sum}, 32'd0);

    // Directed cases with hand-computed results {c_out, ovf, zero, sum}
    send16_directed("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
    send16_directed("sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    send16_directed("sub_8000_1_b", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFE});
    send16_directed("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
    send16_directed("add_1234_c",   16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5556});

    // Random mixed add/sub stream with random back-pressure and bubbles
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bw.a = 16'($urandom); bw.b = 16'($urandom);
      bw.c_in = 1'($urandom); bw.sub = 1'($urandom);
      bw.in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = bw.in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) check_eq("w16_accept_timeout", 32'd0, 32'd1);
      if ($urandom_range(0, 3) == 0) begin
        bw.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bw.in_valid = 1'b0;
    rand_ready = 1'b0;
    bw.out_ready = 1'b1;
    n = 0;
    while (q16.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("w16_drained", q16.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      bw.a = 16'h1000 + 16'(i); bw.b = 16'h0101; bw.c_in = 1'b0; bw.sub = 1'b0;
      bw.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bw.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_out_valid", {31'd0, bw.out_valid}, 32'd0);
    check_eq("midrst_outputs", {13'd0, bw.c_out, bw.ovf, bw.zero, bw.sum}, 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bw.out_valid) seen++;
    end
    check_eq("midrst_flushed", seen, 32'd0);
    send16_directed("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h0100});

    // 8-bit sweep: every A against a spread of B, add/sub, both carry-ins
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int j = 0; j < 20; j++) begin
          if (j < 16) bv = 8'(j * 17);
          else        bv = b_extra[j-16];
          for (int i = 0; i < 256; i++) begin
            b1.a = 8'(i); b1.b = bv; b1.c_in = c[0]; b1.sub = s[0]; b1.in_valid = 1'b1;
            b8.a = 8'(i); b8.b = bv; b8.c_in = c[0]; b8.sub = s[0]; b8.in_valid = 1'b1;
            @(posedge clk);
            #1;
          end
        end
      end
    end
    b1.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("s1_drained", q1.size(), 32'd0);
    check_eq("s8_drained", q8.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
